// File: rtl/sbox_share_arbiter_pkg.sv
// sbox_share_arbiter_pkg: owner encoding, default SubBytes latency and AES S-box helpers.
package sbox_share_arbiter_pkg;
  localparam int LAT_DEFAULT = 2;
  typedef enum logic {OWN_A = 1'b0, OWN_B = 1'b1} owner_t;
  typedef struct packed {
    logic   vld;
    owner_t own;
  } tag_t;
  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  // Inverse as x^254 (maps 0 to 0), followed by the affine transform.
  function automatic logic [7:0] sbox(logic [7:0] x);
    logic [7:0] r, p, e;
    r = 8'h01;
    p = x;
    e = 8'hfe;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gmul(r, p);
      p = gmul(p, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction
  function automatic logic [127:0] sbox128(logic [127:0] x);
    logic [127:0] y;
    for (int i = 0; i < 16; i++) y[8*i +: 8] = sbox(x[8*i +: 8]);
    return y;
  endfunction
endpackage

// File: rtl/sbox_share_arbiter_if.sv
// sbox_share_arbiter_if: request/response ports of both requesters plus busy.
interface sbox_share_arbiter_if #(parameter int W = 128);
  logic         a_valid;
  logic         a_ready;
  logic [W-1:0] a_data;
  logic         a_rsp_valid;
  logic [W-1:0] a_rsp_data;
  logic         b_valid;
  logic         b_ready;
  logic [W-1:0] b_data;
  logic         b_rsp_valid;
  logic [W-1:0] b_rsp_data;
  logic         busy;
  modport master (
    output a_valid, a_data, b_valid, b_data,
    input  a_ready, a_rsp_valid, a_rsp_data, b_ready, b_rsp_valid, b_rsp_data, busy
  );
  modport slave (
    input  a_valid, a_data, b_valid, b_data,
    output a_ready, a_rsp_valid, a_rsp_data, b_ready, b_rsp_valid, b_rsp_data, busy
  );
endinterface

// File: rtl/sbox_share_arbiter_subbytes.sv
// sbox_share_arbiter_subbytes: 128-bit SubBytes with LAT register stages; data path is not reset.
module sbox_share_arbiter_subbytes
  import sbox_share_arbiter_pkg::*;
#(
  parameter int LAT = LAT_DEFAULT
) (
  input  logic         clk,
  input  logic [127:0] ori,
  output logic [127:0] sub
);
  logic [127:0] pipe [LAT];
  always_ff @(posedge clk) begin
    pipe[0] <= sbox128(ori);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign sub = pipe[LAT-1];
endmodule

// File: rtl/sbox_share_arbiter.sv
// sbox_share_arbiter: round-robin sharing of one pipelined SubBytes between round (A) and key (B) paths.
module sbox_share_arbiter
  import sbox_share_arbiter_pkg::*;
#(
  parameter int LAT = LAT_DEFAULT,
  parameter int W   = 128
) (
  input logic                clk,
  input logic                rst,
  sbox_share_arbiter_if.slave bus
);
  tag_t [LAT-1:0] tags;
  owner_t         ptr;
  logic           ga, gb, busy_c;
  logic [W-1:0]   ori, sub;
  always_comb begin
    ga = !rst && bus.a_valid && (!bus.b_valid || ptr == OWN_A);
    gb = !rst && bus.b_valid && (!bus.a_valid || ptr == OWN_B);
    ori = ga ? bus.a_data : gb ? bus.b_data : '0;
    busy_c = 1'b0;
    for (int i = 0; i < LAT; i++) busy_c |= tags[i].vld;
  end
  // Tags shift in lockstep with the SubBytes registers so each result meets its owner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tags <= '0;
      ptr  <= OWN_A;
    end else begin
      tags[0] <= tag_t'{vld: ga || gb, own: gb ? OWN_B : OWN_A};
      for (int i = 1; i < LAT; i++) tags[i] <= tags[i-1];
      if (bus.a_valid && bus.b_valid) ptr <= (ptr == OWN_A) ? OWN_B : OWN_A;
    end
  end
  sbox_share_arbiter_subbytes #(.LAT(LAT)) u_sub (
    .clk(clk),
    .ori(ori),
    .sub(sub)
  );
  assign bus.a_ready     = ga;
  assign bus.b_ready     = gb;
  assign bus.a_rsp_valid = tags[LAT-1].vld && tags[LAT-1].own == OWN_A;
  assign bus.b_rsp_valid = tags[LAT-1].vld && tags[LAT-1].own == OWN_B;
  assign bus.a_rsp_data  = sub;
  assign bus.b_rsp_data  = sub;
  assign bus.busy        = busy_c;
endmodule

// File: doc/sbox_share_arbiter.md
Name: sbox_share_arbiter

Overview:
- Shares the single 128-bit pipelined SubBytes datapath (LAT-cycle latency, no stall) between two requesters: the cipher round datapath (port A) and the key-expansion unit (port B, SubWord).
- Arbitrates issue slots and tags each in-flight operation with its owner.
- Returns each result to the correct requester exactly LAT cycles after issue.
- Sits between the round controller / key scheduler and the SubBytes instance.

Parameters:
- LAT, 2, latency of the instantiated SubBytes in clk cycles; must match the instance, legal 1..4.
- W, 128, datapath width in bits; fixed to 128 for SubBytes.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- a_valid  input  1  round datapath requests a substitution.
- a_ready  output  1  A request accepted this cycle.
- a_data  input  W  state bytes from the round datapath.
- a_rsp_valid  output  1  substituted result for A valid this cycle.
- a_rsp_data  output  W  result for A.
- b_valid  input  1  key expansion requests a substitution.
- b_ready  output  1  B request accepted this cycle.
- b_data  input  W  key word in [31:0]; upper bits don't-care.
- b_rsp_valid  output  1  result for B valid this cycle.
- b_rsp_data  output  W  result for B; only [31:0] meaningful.
- busy  output  1  any operation in flight.

Behaviour:
- Reset (async, rst=1):
  - tag pipeline valid bits = 0, priority pointer = A.
  - a_rsp_valid = b_rsp_valid = 0, busy = 0.
  - a_ready and b_ready = 0 while rst asserted.
  - rsp_data outputs are don't-care while their rsp_valid = 0.
- Arbitration:
  - One grant per cycle, combinational from valid and the priority pointer.
  - Only A valid -> grant A. Only B valid -> grant B.
  - Both valid -> grant the pointer side; pointer flips to the other side on the next edge.
  - Pointer changes only on a contended grant.
  - a_ready = grant_A; b_ready = grant_B; never both 1.
  - A requester may hold valid across cycles; a transfer occurs when valid & ready.
- Issue mux:
  - Granted data drives SubBytes oriBytes.
  - For B, the W-bit word passes through unmodified.
  - With no grant, oriBytes is driven to all zeros (deterministic; tag marks the slot invalid).
- Tag pipeline:
  - LAT-stage shift register of {vld, owner}, aligned with the SubBytes internal registers.
  - Stage 0 captures {grant_any, grant_B} every edge.
- Response:
  - Stage LAT-1 vld & owner=A -> a_rsp_valid=1, a_rsp_data = subBytes.
  - Stage LAT-1 vld & owner=B -> b_rsp_valid=1, b_rsp_data = subBytes.
  - Responses are registered-aligned: a request accepted at edge t appears valid in the cycle after edge t+LAT-1, i.e. LAT cycles after acceptance.
- No backpressure on responses: requesters must absorb a response in the cycle it is valid.
- Throughput: one issue per cycle sustained; back-to-back issues yield back-to-back responses in issue order.
- busy = OR of all tag vld bits.
- Reset mid-operation: in-flight tags are cleared, so those results are dropped and never reported, even though SubBytes data registers are not reset. After rst deasserts, the first response is LAT cycles after the first new grant.
- Simultaneous accept and response on the same side is legal and independent.

Decomposition:
- Shared aes_pkg: owner encoding constants OWN_A=0, OWN_B=1 and the default LAT value, so the key scheduler and round controller agree on latency.
- One sub-module: the existing SubBytes, instantiated once inside.
- Tag pipeline and arbiter stay in this module.

Test Plan:
- Single A request, a_data = 128'h0 -> a_ready=1 same cycle; a_rsp_valid=1 exactly 2 cycles later with 128'h6363…63; b_rsp_valid stays 0.
- Single B request, b_data[31:0] = 32'h00000053 -> b_rsp_data[31:0] = 32'h636363ED after 2 cycles; a_rsp_valid stays 0.
- A and B valid continuously for 6 cycles -> grants alternate A,B,A,B,A,B; responses alternate identically, 2 cycles after each grant; never both rsp_valid in one cycle.
- A-only burst of 4 distinct states -> 4 consecutive a_rsp_valid cycles in order; busy high from the first grant until the last response.
- Assert rst one cycle after issuing an A request -> no a_rsp_valid ever produced for it; busy=0 immediately; a post-reset request responds after 2 cycles.
- Re-run the first test with LAT=1 and a matching SubBytes variant -> response 1 cycle after grant.
